// File: rtl/nested_loop_seq_pkg.sv
// Shared types for the nested loop sequencer: FSM state encoding and index-width helper.
package nested_loop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        DONE = 2'd3
    } state_e;

    // An index must be able to hold the value N, hence clog2(N+1); never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n + 1 <= 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nested_loop_seq_if.sv
// Control/status bundle between the loop sequencer and its controller.
interface nested_loop_seq_if
    import nested_loop_pkg::*;
#(
    parameter int XW = idx_w(10),
    parameter int YW = idx_w(10),
    parameter int CW = 8
);
    logic          start;
    logic          hold;
    logic          abort;
    logic          busy;
    logic          done;
    logic [XW-1:0] x_idx;
    logic [YW-1:0] y_idx;
    logic [CW-1:0] act1;
    logic [CW-1:0] act2;
    logic          act1_vld;

    modport master (
        output start, hold, abort,
        input  busy, done, x_idx, y_idx, act1, act2, act1_vld
    );

    modport slave (
        input  start, hold, abort,
        output busy, done, x_idx, y_idx, act1, act2, act1_vld
    );
endinterface

// File: rtl/nested_loop_seq_loop_counter.sv
// Modulo-N index counter with synchronous clear (priority over enable) and a last flag.
// Latency: one cycle from en/clr to cnt; last_o is a decode of the current count.
module loop_counter #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last_o = (cnt_q == W'(N - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nested_loop_seq.sv
// Two-level loop sequencer: outer index x, inner index y, act1 snapshots the inner accumulator act2.
// Latency: start to done = OUTER_N*(INNER_N+1)+1 cycles; hold stalls 1:1, abort returns to IDLE next cycle.
module nested_loop_seq
    import nested_loop_pkg::*;
#(
    parameter int OUTER_N = 10,
    parameter int INNER_N = 10,
    parameter int CW      = 8,
    parameter int ORDER   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    nested_loop_seq_if.slave bus
);
    localparam int XW = idx_w(OUTER_N);
    localparam int YW = idx_w(INNER_N);

    state_e        state_q, state_d;
    logic [CW-1:0] act1_q, act1_d;
    logic [CW-1:0] act2_q, act2_d;
    logic          vld_q, vld_d;

    logic          x_en, x_clr, x_last;
    logic          y_en, y_clr, y_last;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    loop_counter #(.N(OUTER_N), .W(XW)) u_outer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (x_en),
        .clr_i  (x_clr),
        .cnt_o  (x_cnt),
        .last_o (x_last)
    );

    loop_counter #(.N(INNER_N), .W(YW)) u_inner (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (y_en),
        .clr_i  (y_clr),
        .cnt_o  (y_cnt),
        .last_o (y_last)
    );

    always_comb begin
        state_d = state_q;
        act1_d  = act1_q;
        act2_d  = act2_q;
        vld_d   = 1'b0;
        x_en    = 1'b0;
        x_clr   = 1'b0;
        y_en    = 1'b0;
        y_clr   = 1'b0;

        // Abort beats hold, and the accumulators are deliberately left untouched.
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            x_clr   = 1'b1;
            y_clr   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d = HEAD;
                        x_clr   = 1'b1;
                        y_clr   = 1'b1;
                        act1_d  = '0;
                        act2_d  = '0;
                    end
                end
                HEAD: begin
                    if (!bus.hold) begin
                        if (ORDER == 0) begin
                            act1_d = act2_q;
                            vld_d  = 1'b1;
                        end
                        state_d = BODY;
                    end
                end
                BODY: begin
                    if (!bus.hold) begin
                        act2_d = act2_q + CW'(1);
                        y_en   = 1'b1;
                        if (y_last) begin
                            if (ORDER != 0) begin
                                act1_d = act2_q + CW'(1);
                                vld_d  = 1'b1;
                            end
                            // x wraps to 0 on its final step, so DONE already shows cleared indices.
                            x_en    = 1'b1;
                            state_d = x_last ? DONE : HEAD;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    x_clr   = 1'b1;
                    y_clr   = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            act1_q  <= '0;
            act2_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act1_q  <= act1_d;
            act2_q  <= act2_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.busy     = (state_q == HEAD) || (state_q == BODY);
    assign bus.done     = (state_q == DONE);
    assign bus.x_idx    = x_cnt;
    assign bus.y_idx    = y_cnt;
    assign bus.act1     = act1_q;
    assign bus.act2     = act2_q;
    assign bus.act1_vld = vld_q;
endmodule

// File: tb/tb_nested_loop_seq.sv
// Directed, table-driven bench for nested_loop_seq across four parameter sets.
module tb_nested_loop_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_s [4];
    logic       hold_s  [4];
    logic       abort_s [4];
    logic       busy_s  [4];
    logic       done_s  [4];
    logic       vld_s   [4];
    logic [7:0] x_s     [4];
    logic [7:0] y_s     [4];
    logic [7:0] a1_s    [4];
    logic [7:0] a2_s    [4];

    // 0: defaults ORDER=0, 1: defaults ORDER=1, 2: CW=4 3x7, 3: 1x1
    nested_loop_seq_if #(.XW(4), .YW(4), .CW(8)) if0 ();
    nested_loop_seq_if #(.XW(4), .YW(4), .CW(8)) if1 ();
    nested_loop_seq_if #(.XW(2), .YW(3), .CW(4)) if2 ();
    nested_loop_seq_if #(.XW(1), .YW(1), .CW(8)) if3 ();

    nested_loop_seq #(.OUTER_N(10), .INNER_N(10), .CW(8), .ORDER(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    nested_loop_seq #(.OUTER_N(10), .INNER_N(10), .CW(8), .ORDER(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    nested_loop_seq #(.OUTER_N(3),  .INNER_N(7),  .CW(4), .ORDER(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    nested_loop_seq #(.OUTER_N(1),  .INNER_N(1),  .CW(8), .ORDER(0)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.start = start_s[0]; assign if0.hold = hold_s[0]; assign if0.abort = abort_s[0];
    assign if1.start = start_s[1]; assign if1.hold = hold_s[1]; assign if1.abort = abort_s[1];
    assign if2.start = start_s[2]; assign if2.hold = hold_s[2]; assign if2.abort = abort_s[2];
    assign if3.start = start_s[3]; assign if3.hold = hold_s[3]; assign if3.abort = abort_s[3];

    assign busy_s[0] = if0.busy; assign done_s[0] = if0.done; assign vld_s[0] = if0.act1_vld;
    assign busy_s[1] = if1.busy; assign done_s[1] = if1.done; assign vld_s[1] = if1.act1_vld;
    assign busy_s[2] = if2.busy; assign done_s[2] = if2.done; assign vld_s[2] = if2.act1_vld;
    assign busy_s[3] = if3.busy; assign done_s[3] = if3.done; assign vld_s[3] = if3.act1_vld;

    assign x_s[0] = 8'(if0.x_idx); assign y_s[0] = 8'(if0.y_idx); assign a1_s[0] = 8'(if0.act1); assign a2_s[0] = 8'(if0.act2);
    assign x_s[1] = 8'(if1.x_idx); assign y_s[1] = 8'(if1.y_idx); assign a1_s[1] = 8'(if1.act1); assign a2_s[1] = 8'(if1.act2);
    assign x_s[2] = 8'(if2.x_idx); assign y_s[2] = 8'(if2.y_idx); assign a1_s[2] = 8'(if2.act1); assign a2_s[2] = 8'(if2.act2);
    assign x_s[3] = 8'(if3.x_idx); assign y_s[3] = 8'(if3.y_idx); assign a1_s[3] = 8'(if3.act1); assign a2_s[3] = 8'(if3.act2);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Cycle 0 is the cycle in which start is high; -1 disables a field.
    typedef struct {
        string name;
        int    dut;
        int    restart_at;
        int    hold_at;
        int    hold_len;
        int    abort_at;
        int    fx, fy, fa2;
        int    exp_done;
        int    exp_busy;
        int    vld_first, vld_step, vld_cnt, mask;
        int    exp_a1, exp_a2;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        int  c, done_cyc, ndone, nbusy, nvld, k;
        bit  fin;
        k = v.dut;
        c = 0; done_cyc = -1; ndone = 0; nbusy = 0; nvld = 0; fin = 1'b0;
        @(negedge clk);
        start_s[k] = 1'b1;
        while (!fin) begin
            @(negedge clk);
            c++;
            start_s[k] = (c == v.restart_at);
            if (busy_s[k]) nbusy++;
            if (done_s[k]) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (vld_s[k]) begin
                chk({v.name, "_vld_val"}, int'(a1_s[k]), (v.vld_first + nvld * v.vld_step) & v.mask);
                nvld++;
            end
            if (v.hold_len > 0 && c >= v.hold_at && c <= v.hold_at + v.hold_len && busy_s[k]) begin
                chk({v.name, "_frz_x"}, int'(x_s[k]), v.fx);
                chk({v.name, "_frz_y"}, int'(y_s[k]), v.fy);
                chk({v.name, "_frz_a2"}, int'(a2_s[k]), v.fa2);
                if (c > v.hold_at) chk({v.name, "_frz_vld"}, int'(vld_s[k]), 0);
            end
            hold_s[k]  = (c >= v.hold_at && c < v.hold_at + v.hold_len);
            abort_s[k] = (c == v.abort_at);
            if (c > 1 && !busy_s[k] && !done_s[k]) fin = 1'b1;
            if (c >= 400) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: still running at cycle %0d, expected idle by %0d", v.name, c, v.exp_busy + 2);
                fin = 1'b1;
            end
        end
        hold_s[k]  = 1'b0;
        abort_s[k] = 1'b0;
        chk({v.name, "_done_cyc"}, done_cyc, v.exp_done);
        chk({v.name, "_done_cnt"}, ndone, (v.exp_done < 0) ? 0 : 1);
        chk({v.name, "_busy_cnt"}, nbusy, v.exp_busy);
        chk({v.name, "_vld_cnt"}, nvld, v.vld_cnt);
        chk({v.name, "_act1"}, int'(a1_s[k]), v.exp_a1);
        chk({v.name, "_act2"}, int'(a2_s[k]), v.exp_a2);
        chk({v.name, "_x_end"}, int'(x_s[k]), 0);
        chk({v.name, "_y_end"}, int'(y_s[k]), 0);
    endtask

    initial begin
        //          name          dut rst  hat hl abt fx fy fa2 done busy vf vs vc mask a1  a2
        vecs[0] = '{"t1_ord0",     0, -1,  -1, 0, -1, 0, 0, 0,  111, 110, 0, 10, 10, 255, 90, 100};
        vecs[1] = '{"t2_ord1",     1, -1,  -1, 0, -1, 0, 0, 0,  111, 110, 10, 10, 10, 255, 100, 100};
        vecs[2] = '{"t3_hold",     0, -1,  39, 5, -1, 3, 4, 34, 116, 115, 0, 10, 10, 255, 90, 100};
        vecs[3] = '{"t4_abort",    0, -1,  -1, 0, 31, 0, 0, 0,  -1,  31,  0, 10, 3,  255, 20, 27};
        vecs[4] = '{"t5_wrap",     2, -1,  -1, 0, -1, 0, 0, 0,  25,  24,  0, 7,  3,  15,  14, 5};
        vecs[5] = '{"t6_restart",  0, 50,  -1, 0, -1, 0, 0, 0,  111, 110, 0, 10, 10, 255, 90, 100};
        vecs[6] = '{"t6_min",      3, -1,  -1, 0, -1, 0, 0, 0,  3,   2,   0, 1,  1,  255, 0, 1};
        vecs[7] = '{"hold_abort",  0, -1,  20, 10, 25, 1, 7, 17, -1, 25,  0, 10, 2,  255, 10, 17};

        for (int i = 0; i < 4; i++) begin
            start_s[i] = 1'b0;
            hold_s[i]  = 1'b0;
            abort_s[i] = 1'b0;
        end

        #12;
        for (int i = 0; i < 4; i++) begin
            chk("rst_busy", int'(busy_s[i]), 0);
            chk("rst_done", int'(done_s[i]), 0);
            chk("rst_x", int'(x_s[i]), 0);
            chk("rst_a2", int'(a2_s[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // A fresh start clears the accumulators left over from an aborted run.
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("clr_busy", int'(busy_s[0]), 1);
        chk("clr_act1", int'(a1_s[0]), 0);
        chk("clr_act2", int'(a2_s[0]), 0);
        chk("clr_x", int'(x_s[0]), 0);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("clr_abort_busy", int'(busy_s[0]), 0);
        chk("clr_abort_done", int'(done_s[0]), 0);

        // start and abort together in IDLE: stays idle, accumulators untouched.
        start_s[1] = 1'b1;
        abort_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        abort_s[1] = 1'b0;
        chk("sa_busy", int'(busy_s[1]), 0);
        chk("sa_act1", int'(a1_s[1]), 100);
        chk("sa_act2", int'(a2_s[1]), 100);
        @(negedge clk);
        chk("sa_busy2", int'(busy_s[1]), 0);

        // Asynchronous reset in the middle of a run.
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst_act2", int'(a2_s[0]), 17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_s[0]), 0);
        chk("mid_rst_x", int'(x_s[0]), 0);
        chk("mid_rst_y", int'(y_s[0]), 0);
        chk("mid_rst_act1", int'(a1_s[0]), 0);
        chk("mid_rst_act2", int'(a2_s[0]), 0);
        chk("mid_rst_vld", int'(vld_s[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy_s[0]), 0);
        chk("post_rst_done", int'(done_s[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
